// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register with valid/ready handshake,
// stall/flush, optional 2-entry skid buffer and a bubble counter.
module pipe_stage_reg #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 101,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_acc;
    logic              out_acc;
    logic              m_free;

    assign out_acc = m_valid_q & ready_i & ~stall_i;
    assign m_free  = ~m_valid_q | out_acc;
    // With the skid entry, ready depends only on a flop
    assign ready_o = (SKID != 0) ? ~s_valid_q : m_free;
    assign in_acc  = valid_i & ready_o;

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;
        if (flush_i) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (m_free && s_valid_q) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = s_ctrl_q;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (m_free && in_acc) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = ctrl_i;
                m_data_d  = data_i;
            end else if (m_free) begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
            end
            if (in_acc && !m_free) begin
                s_valid_d = 1'b1;
                s_ctrl_d  = ctrl_i;
                s_data_d  = data_i;
            end
        end else begin
            if (in_acc) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = ctrl_i;
                m_data_d  = data_i;
            end else if (m_free) begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (!m_valid_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_ctrl_q  <= '0;
            s_data_q  <= '0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign valid_o      = m_valid_q;
    assign ctrl_o       = m_ctrl_q;
    assign data_o       = m_data_q;
    assign bubble_cnt_o = cnt_q;

endmodule
